// File: rtl/lns_fma_if.sv
// Operand/result stream bundle for the LNS fused multiply-add pipeline.
// Words are {sign, log[LOG_W-1:0]}; master drives operands and out_ready.
interface lns_fma_if #(
  parameter int LOG_W = 11
);
  logic           in_valid;
  logic           in_ready;
  logic [LOG_W:0] a;
  logic [LOG_W:0] b;
  logic [LOG_W:0] c;
  logic           out_valid;
  logic           out_ready;
  logic [LOG_W:0] out;
  logic           out_cancel;
  logic           out_ovf;

  modport master (
    output in_valid, a, b, c, out_ready,
    input  in_ready, out_valid, out, out_cancel, out_ovf
  );

  modport slave (
    input  in_valid, a, b, c, out_ready,
    output in_ready, out_valid, out, out_cancel, out_ovf
  );
endinterface

// File: rtl/lns_fma_pipe.sv
// Three-stage LNS fused multiply-add, out = a*b + c, with global-enable flow control.
// Define LNS_SAT_EN to clamp out-of-range results; otherwise the log field wraps.
module lns_fma_pipe #(
  parameter int LOG_W  = 11,
  parameter int FRAC_W = 7
) (
  input logic      clk,
  input logic      rst,
  lns_fma_if.slave io
);
  localparam int ROM_N  = (FRAC_W + 3) << FRAC_W;
  localparam int ROM_AW = $clog2(ROM_N);
  localparam int F_W    = LOG_W + 2;
  localparam int LIM    = 1 << (LOG_W - 1);
  localparam logic [LOG_W+1:0]        ROM_LIM = (LOG_W + 2)'(ROM_N);
  localparam logic signed [LOG_W+2:0] R_MAX   = (LOG_W + 3)'(LIM - 1);
  localparam logic signed [LOG_W+2:0] R_MIN   = (LOG_W + 3)'(-LIM);

  function automatic int round_haz(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

  function automatic int sb_calc(input int i);
    real x;
    x = -real'(i) / real'(1 << FRAC_W);
    return round_haz(real'(1 << FRAC_W) * $ln(1.0 + $exp(x * $ln(2.0))) / $ln(2.0));
  endfunction

  // Entry 0 of db is -inf; that case is taken by the cancellation path instead.
  function automatic int db_calc(input int i);
    real x;
    if (i == 0) return 0;
    x = -real'(i) / real'(1 << FRAC_W);
    return round_haz(real'(1 << FRAC_W) * $ln(1.0 - $exp(x * $ln(2.0))) / $ln(2.0));
  endfunction

  function automatic logic range_err(input logic signed [LOG_W+2:0] r);
    return (r > R_MAX) || (r < R_MIN);
  endfunction

  function automatic logic [LOG_W-1:0] fit_log(input logic signed [LOG_W+2:0] r);
`ifdef LNS_SAT_EN
    if (r > R_MAX) return R_MAX[LOG_W-1:0];
    if (r < R_MIN) return R_MIN[LOG_W-1:0];
`endif
    return r[LOG_W-1:0];
  endfunction

  logic signed [F_W-1:0] sb_rom [ROM_N];
  logic signed [F_W-1:0] db_rom [ROM_N];

  for (genvar i = 0; i < ROM_N; i++) begin : g_rom
    assign sb_rom[i] = F_W'(sb_calc(i));
    assign db_rom[i] = F_W'(db_calc(i));
  end

  logic en;
  logic vld_p0, vld_p1, vld_p2;

  assign en           = !vld_p2 || io.out_ready;
  assign io.in_ready  = en;
  assign io.out_valid = vld_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (en) begin
      vld_p0 <= io.in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // Stage 1: multiply is a log-domain add, widened by one bit so it never wraps
  logic signed [LOG_W-1:0] a_log, b_log;
  logic                    p_sign_p0, c_sign_p0;
  logic signed [LOG_W:0]   p_log_p0;
  logic signed [LOG_W-1:0] c_log_p0;

  assign a_log = io.a[LOG_W-1:0];
  assign b_log = io.b[LOG_W-1:0];

  always_ff @(posedge clk) begin
    if (en) begin
      p_sign_p0 <= io.a[LOG_W] ^ io.b[LOG_W];
      p_log_p0  <= {a_log[LOG_W-1], a_log} + {b_log[LOG_W-1], b_log};
      c_sign_p0 <= io.c[LOG_W];
      c_log_p0  <= io.c[LOG_W-1:0];
    end
  end

  // Stage 2: align on the larger log, keep the non-positive distance d
  logic signed [LOG_W+1:0] p_ext, c_ext, diff, mag;
  logic                    p_ge;
  logic signed [LOG_W:0]   m_p1;
  logic signed [LOG_W+1:0] d_p1;
  logic                    same_p1, sign_p1;

  always_comb begin
    p_ext = {p_log_p0[LOG_W], p_log_p0};
    c_ext = {{2{c_log_p0[LOG_W-1]}}, c_log_p0};
    diff  = p_ext - c_ext;
    p_ge  = !diff[LOG_W+1];
    mag   = p_ge ? diff : -diff;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      m_p1    <= p_ge ? p_log_p0 : {c_log_p0[LOG_W-1], c_log_p0};
      d_p1    <= -mag;
      same_p1 <= (p_sign_p0 == c_sign_p0);
      sign_p1 <= p_ge ? p_sign_p0 : c_sign_p0;
    end
  end

  // Stage 3: Gaussian-log correction from the ROMs, then range handling
  logic [LOG_W+1:0]        idx;
  logic [ROM_AW-1:0]       rom_a;
  logic signed [F_W-1:0]   f_val;
  logic signed [LOG_W+2:0] r_sum;
  logic                    cancel;
  logic [LOG_W:0]          out_p2;
  logic                    cancel_p2, ovf_p2;

  always_comb begin
    idx   = -d_p1;
    rom_a = idx[ROM_AW-1:0];
    f_val = '0;
    if (idx < ROM_LIM) f_val = same_p1 ? sb_rom[rom_a] : db_rom[rom_a];
    r_sum  = {{2{m_p1[LOG_W]}}, m_p1} + {f_val[F_W-1], f_val};
    cancel = !same_p1 && (d_p1 == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_p2    <= '0;
      cancel_p2 <= 1'b0;
      ovf_p2    <= 1'b0;
    end else if (en && vld_p1) begin
      if (cancel) begin
        out_p2    <= {1'b0, R_MIN[LOG_W-1:0]};
        cancel_p2 <= 1'b1;
        ovf_p2    <= 1'b0;
      end else begin
        out_p2    <= {sign_p1, fit_log(r_sum)};
        cancel_p2 <= 1'b0;
        ovf_p2    <= range_err(r_sum);
      end
    end
  end

  assign io.out        = out_p2;
  assign io.out_cancel = cancel_p2;
  assign io.out_ovf    = ovf_p2;
endmodule

// File: tb/tb_lns_fma_pipe.sv
// Randomized bench for lns_fma_pipe against a real-valued a*b+c reference.
// Expected words for the overflow case follow the LNS_SAT_EN build option.
module tb_lns_fma_pipe;
  localparam int LW = 11;
  localparam int FW = 7;

  typedef logic [LW:0] word_t;
  typedef struct {
    word_t a;
    word_t b;
    word_t c;
    int    cyc;
    bit    has_exp;
    word_t exp_out;
    bit    exp_cancel;
    bit    exp_ovf;
  } item_t;

  localparam word_t CANCEL_W = {1'b0, 1'b1, {(LW-1){1'b0}}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lns_fma_if #(.LOG_W(LW)) io ();
  lns_fma_pipe #(.LOG_W(LW), .FRAC_W(FW)) dut (.clk(clk), .rst(rst), .io(io));

  item_t sb[$];
  int    checks  = 0;
  int    errors  = 0;
  int    cyc     = 0;
  int    n_out   = 0;
  bit    chk_lat = 1'b1;

  task automatic chk(input string tag, input longint obs, input longint exp, input longint tol = 0);
    checks++;
    if (((obs > exp) ? obs - exp : exp - obs) > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic word_t mk(input logic s, input int lg);
    logic [LW-1:0] f;
    f = lg[LW-1:0];
    return {s, f};
  endfunction

  function automatic int rnd_log(input int lo, input int hi);
    return lo + int'($urandom_range(hi - lo));
  endfunction

  function automatic item_t mk_item(input word_t a, input word_t b, input word_t c);
    item_t t;
    t.a = a; t.b = b; t.c = c; t.cyc = 0;
    t.has_exp = 1'b0; t.exp_out = '0; t.exp_cancel = 1'b0; t.exp_ovf = 1'b0;
    return t;
  endfunction

  function automatic item_t with_exp(input item_t t, input word_t o, input bit cn, input bit ov);
    item_t r;
    r = t; r.has_exp = 1'b1; r.exp_out = o; r.exp_cancel = cn; r.exp_ovf = ov;
    return r;
  endfunction

  function automatic item_t rnd_item();
    return mk_item(mk(1'($urandom_range(1)), rnd_log(-400, 400)),
                   mk(1'($urandom_range(1)), rnd_log(-400, 400)),
                   mk(1'($urandom_range(1)), rnd_log(-800, 800)));
  endfunction

  function automatic real wval(input word_t w);
    real m;
    m = 2.0 ** (real'($signed(w[LW-1:0])) / real'(1 << FW));
    return w[LW] ? -m : m;
  endfunction

  // Reference: real-valued a*b+c, then back into the log domain
  task automatic ref_model(input item_t it, output bit canc, output bit sgn, output real lg);
    real p, vc, v, av, scale;
    p     = wval(it.a) * wval(it.b);
    vc    = wval(it.c);
    v     = p + vc;
    av    = (v < 0.0) ? -v : v;
    scale = (p < 0.0) ? -p : p;
    if (((vc < 0.0) ? -vc : vc) > scale) scale = (vc < 0.0) ? -vc : vc;
    canc  = (av <= scale * 1.0e-9);
    sgn   = (v < 0.0);
    lg    = canc ? 0.0 : $ln(av) / $ln(2.0) * real'(1 << FW);
  endtask

  task automatic consume();
    item_t  t;
    bit     canc, sgn;
    real    lg;
    longint obs;
    if (sb.size() == 0) begin
      chk("spurious", longint'(io.out_valid), 0);
      return;
    end
    t = sb.pop_front();
    n_out++;
    ref_model(t, canc, sgn, lg);
    if (chk_lat) chk("latency", longint'(cyc - t.cyc), 3);
    if (t.has_exp) begin
      chk("dir_word", longint'(io.out), longint'(t.exp_out));
      chk("dir_cancel", longint'(io.out_cancel), longint'(t.exp_cancel));
      chk("dir_ovf", longint'(io.out_ovf), longint'(t.exp_ovf));
    end
    if (canc) begin
      chk("cancel_flag", longint'(io.out_cancel), 1);
      chk("cancel_word", longint'(io.out), longint'(CANCEL_W));
      chk("cancel_ovf", longint'(io.out_ovf), 0);
    end else if (lg > 1026.0 || lg < -1026.0) begin
      chk("ovf_flag", longint'(io.out_ovf), 1);
    end else if (lg < 1020.0 && lg > -1020.0) begin
      obs = longint'($signed(io.out[LW-1:0]));
      chk("flags", longint'({io.out_cancel, io.out_ovf}), 0);
      chk("sign", longint'(io.out[LW]), longint'(sgn));
      chk("log", obs, longint'($rtoi((lg >= 0.0) ? lg + 0.5 : lg - 0.5)), 1);
    end
  endtask

  task automatic step(input bit iv, input item_t it, input bit ordy, input bit rs, output bit acc);
    item_t t;
    @(negedge clk);
    rst          = rs;
    io.in_valid  = iv;
    io.a         = it.a;
    io.b         = it.b;
    io.c         = it.c;
    io.out_ready = ordy;
    #1;
    acc = iv && !rs && io.in_ready;
    if (rs) begin
      sb.delete();
    end else begin
      if (io.out_valid && io.out_ready) consume();
      if (acc) begin
        t = it;
        t.cyc = cyc;
        sb.push_back(t);
      end
    end
    cyc++;
  endtask

  initial begin
    item_t z, st[8], r1, r2, r3;
    bit    acc, ordy, prev_stall;
    word_t held_out;
    logic [1:0] held_flags;
    int    n0, idx;

    z = mk_item('0, '0, '0);
    io.in_valid = 1'b0; io.a = '0; io.b = '0; io.c = '0; io.out_ready = 1'b1;

    step(0, z, 1, 1, acc);
    step(0, z, 1, 1, acc);
    step(0, z, 1, 0, acc);
    chk("rst_out_valid", longint'(io.out_valid), 0);
    chk("rst_out", longint'(io.out), 0);
    chk("rst_cancel", longint'(io.out_cancel), 0);
    chk("rst_ovf", longint'(io.out_ovf), 0);
    chk("rst_in_ready", longint'(io.in_ready), 1);

    // Directed words with exactly known results
    step(1, with_exp(mk_item(mk(0, 0), mk(0, 0), mk(0, 0)), mk(0, 128), 0, 0), 1, 0, acc);
    step(1, with_exp(mk_item(mk(0, 128), mk(0, -128), mk(1, 0)), mk(0, -1024), 1, 0), 1, 0, acc);
    chk("early_valid1", longint'(io.out_valid), 0);
`ifdef LNS_SAT_EN
    step(1, with_exp(mk_item(mk(0, 1023), mk(0, 1023), mk(0, -1024)), mk(0, 1023), 0, 1), 1, 0, acc);
`else
    step(1, with_exp(mk_item(mk(0, 1023), mk(0, 1023), mk(0, -1024)), mk(0, -2), 0, 1), 1, 0, acc);
`endif
    chk("early_valid2", longint'(io.out_valid), 0);
    step(1, with_exp(mk_item(mk(1, 0), mk(0, 0), mk(0, -128)), mk(1, -128), 0, 0), 1, 0, acc);
    step(1, with_exp(mk_item(mk(0, 0), mk(0, 0), mk(0, -128)), mk(0, 75), 0, 0), 1, 0, acc);
    repeat (6) step(0, z, 1, 0, acc);

    // Back-to-back random stream
    for (int i = 0; i < 40; i++) step(1, rnd_item(), 1, 0, acc);
    repeat (5) step(0, z, 1, 0, acc);

    // Stall window: out_ready low for stream cycles 2..6
    chk_lat = 1'b0;
    for (int i = 0; i < 8; i++) st[i] = rnd_item();
    n0 = n_out; idx = 0; prev_stall = 1'b0; held_out = '0; held_flags = '0;
    for (int k = 0; k < 60; k++) begin
      ordy = !(k >= 2 && k <= 6);
      step(idx < 8, st[(idx < 8) ? idx : 0], ordy, 0, acc);
      if (acc) idx++;
      if (prev_stall) begin
        chk("hold_out", longint'(io.out), longint'(held_out));
        chk("hold_flags", longint'({io.out_cancel, io.out_ovf}), longint'(held_flags));
      end
      if (io.out_valid && !ordy) chk("stall_in_ready", longint'(io.in_ready), 0);
      prev_stall = io.out_valid && !ordy;
      held_out   = io.out;
      held_flags = {io.out_cancel, io.out_ovf};
      if (idx == 8 && sb.size() == 0) break;
    end
    chk("stall_count", longint'(n_out - n0), 8);
    chk_lat = 1'b1;

    // Reset with two items in flight: neither may appear
    r1 = rnd_item(); r2 = rnd_item(); r3 = rnd_item();
    step(1, r1, 1, 0, acc);
    step(1, r2, 1, 0, acc);
    step(0, z, 1, 1, acc);
    step(0, z, 1, 0, acc);
    chk("flush_valid", longint'(io.out_valid), 0);
    n0 = n_out;
    repeat (4) step(0, z, 1, 0, acc);
    step(1, r3, 1, 0, acc);
    repeat (5) step(0, z, 1, 0, acc);
    chk("post_rst_count", longint'(n_out - n0), 1);

    // Small-log sweep with b = 1.0 and negative c
    for (int la = -16; la <= 15; la++)
      for (int lc = -16; lc <= 15; lc++)
        step(1, mk_item(mk(0, la), mk(0, 0), mk(1, lc)), 1, 0, acc);
    repeat (6) step(0, z, 1, 0, acc);

    chk("sb_empty", longint'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
